// File: rtl/rv32_pkg.sv
// Shared RV32I datapath types and constants, imported by regfile, alu and the datapath.
//   XLEN       : integer register / operand width
//   REG_AW     : architectural register address width
//   word_t     : one XLEN-wide data word
//   reg_addr_t : register index (rs1/rs2/rd)
//   REG_ZERO   : index of the hardwired-zero register x0
package rv32_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef logic [XLEN-1:0]   word_t;
    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_if.sv
// Register file access bundle between the single-cycle datapath and regfile.
//   A1/A2  -> read port addresses (rs1, rs2), RD1/RD2 <- read data
//   A3/WE3/WD3 -> writeback address, enable and data
//   ADBG   -> debug read address, RDBG <- debug read data
// master: datapath side (drives addresses and writeback)
// slave : regfile side (drives read data)
interface regfile_if
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN = rv32_pkg::XLEN
) ();

    reg_addr_t        A1;
    reg_addr_t        A2;
    reg_addr_t        A3;
    logic             WE3;
    logic [XLEN-1:0]  WD3;
    logic [XLEN-1:0]  RD1;
    logic [XLEN-1:0]  RD2;
    reg_addr_t        ADBG;
    logic [XLEN-1:0]  RDBG;

    modport master (
        output A1, A2, A3, WE3, WD3, ADBG,
        input  RD1, RD2, RDBG
    );

    modport slave (
        input  A1, A2, A3, WE3, WD3, ADBG,
        output RD1, RD2, RDBG
    );

endinterface

// File: rtl/regfile_rdport.sv
// One combinational register file read port: selects the stored word for
// addr, forces x0 to zero and, when REGFILE_BYPASS_EN is defined, forwards
// the in-flight write data for a same-cycle write to the same register.
//   addr  : register index to read
//   regs  : flattened storage for x1..x(NREGS-1)
//   rst_n, we, wa, wd : writeback port (present only with REGFILE_BYPASS_EN)
//   rd    : read data (combinational)
module regfile_rdport
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN  = rv32_pkg::XLEN,
    parameter int unsigned NREGS = 32
) (
    input  reg_addr_t                     addr,
    input  logic [NREGS-1:1][XLEN-1:0]    regs,
    output logic [XLEN-1:0]               rd
`ifdef REGFILE_BYPASS_EN
    ,
    input  logic                          rst_n,
    input  logic                          we,
    input  reg_addr_t                     wa,
    input  logic [XLEN-1:0]               wd
`endif
);

    // Address decode: x0 and out-of-range indices fall through to zero.
    always_comb begin
        rd = '0;
        for (int unsigned i = 1; i < NREGS; i++) begin
            if (addr == reg_addr_t'(i)) begin
                rd = regs[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        // Write-through; never for x0 and never while reset is asserted.
        if (rst_n && we && (wa != REG_ZERO) && (wa == addr)) begin
            rd = wd;
        end
`endif
    end

endmodule

// File: rtl/regfile.sv
// RV32I architectural integer register file.
// Two combinational operand read ports (RD1 -> alu.a, RD2 -> b source mux),
// one debug read port, one registered writeback port. x0 has no storage and
// always reads zero; x1..x(NREGS-1) clear asynchronously on reset.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-through
// forwarding on all three read ports; storage behaviour is unchanged).
//   clk   : core clock, writes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : regfile_if.slave (A1/A2/A3/WE3/WD3/ADBG in, RD1/RD2/RDBG out)
module regfile
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN  = rv32_pkg::XLEN,
    parameter int unsigned NREGS = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    regfile_if.slave  bus
);

    logic [NREGS-1:1][XLEN-1:0] regs;

    // Writeback storage; index 0 never matches, so writes to x0 are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else begin
            for (int unsigned i = 1; i < NREGS; i++) begin
                if (bus.WE3 && (bus.A3 == reg_addr_t'(i))) begin
                    regs[i] <= bus.WD3;
                end
            end
        end
    end

    regfile_rdport #(.XLEN(XLEN), .NREGS(NREGS)) u_rd1 (
        .addr  (bus.A1),
        .regs  (regs),
        .rd    (bus.RD1)
`ifdef REGFILE_BYPASS_EN
        ,
        .rst_n (rst_n),
        .we    (bus.WE3),
        .wa    (bus.A3),
        .wd    (bus.WD3)
`endif
    );

    regfile_rdport #(.XLEN(XLEN), .NREGS(NREGS)) u_rd2 (
        .addr  (bus.A2),
        .regs  (regs),
        .rd    (bus.RD2)
`ifdef REGFILE_BYPASS_EN
        ,
        .rst_n (rst_n),
        .we    (bus.WE3),
        .wa    (bus.A3),
        .wd    (bus.WD3)
`endif
    );

    regfile_rdport #(.XLEN(XLEN), .NREGS(NREGS)) u_rdbg (
        .addr  (bus.ADBG),
        .regs  (regs),
        .rd    (bus.RDBG)
`ifdef REGFILE_BYPASS_EN
        ,
        .rst_n (rst_n),
        .we    (bus.WE3),
        .wa    (bus.A3),
        .wd    (bus.WD3)
`endif
    );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed vector table, hand-written
// reset / read-after-write sequences, and random traffic against an
// array-based reference model. Honours REGFILE_BYPASS_EN like the RTL.
module tb_regfile;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [32];

    regfile_if #(.XLEN(32)) rf_if ();

    regfile #(.XLEN(32), .NREGS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rf_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  ad;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                         input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
        rf_if.WE3  = we;
        rf_if.A3   = a3;
        rf_if.WD3  = wd;
        rf_if.A1   = a1;
        rf_if.A2   = a2;
        rf_if.ADBG = ad;
    endtask

    // Reference read: zero register, reset, optional write-through, else stored value.
    function automatic logic [31:0] mread(input logic [4:0] a);
        if (a == 5'd0)  return 32'd0;
        if (!rst_n)     return 32'd0;
        if (BYP && rf_if.WE3 && rf_if.A3 == a) return rf_if.WD3;
        return model[a];
    endfunction

    // Advance one clock, committing the presented write into the model.
    task automatic edge_step();
        logic        do_wr;
        logic [4:0]  wa;
        logic [31:0] wv;
        @(posedge clk);
        do_wr = rst_n && rf_if.WE3 && (rf_if.A3 != 5'd0);
        wa    = rf_if.A3;
        wv    = rf_if.WD3;
        if (do_wr) model[wa] = wv;
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
    endtask

    initial begin
        clear_model();
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);

        // Reset state, including a write attempted while reset is held.
        #2;
        drive(1'b1, 5'd1, 32'h0000_FFFF, 5'd1, 5'd31, 5'd7);
        #1;
        check("reset_rd1", rf_if.RD1, 32'd0);
        check("reset_rd2", rf_if.RD2, 32'd0);
        check("reset_rdbg", rf_if.RDBG, 32'd0);
        @(posedge clk);
        #1;
        rf_if.WE3 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_write_lost", rf_if.RD1, 32'd0);
        edge_step();

        // Directed vector table: reads are checked before the row's write edge.
        tbl[0] = '{1'b1, 5'd1,  32'hFFFF_FFFB, 5'd0,  5'd0,  5'd0,  32'd0,         32'd0,         32'd0};
        tbl[1] = '{1'b1, 5'd2,  32'h0000_0003, 5'd1,  5'd0,  5'd1,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB};
        tbl[2] = '{1'b0, 5'd0,  32'd0,         5'd1,  5'd2,  5'd2,  32'hFFFF_FFFB, 32'd3,         32'd3};
        tbl[3] = '{1'b1, 5'd0,  32'hDEAD_BEEF, 5'd0,  5'd1,  5'd0,  32'd0,         32'hFFFF_FFFB, 32'd0};
        tbl[4] = '{1'b1, 5'd9,  32'hA5A5_A5A5, 5'd0,  5'd2,  5'd1,  32'd0,         32'd3,         32'hFFFF_FFFB};
        tbl[5] = '{1'b1, 5'd10, 32'h1234_5678, 5'd9,  5'd9,  5'd9,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
        tbl[6] = '{1'b0, 5'd0,  32'd0,         5'd10, 5'd9,  5'd0,  32'h1234_5678, 32'hA5A5_A5A5, 32'd0};
        tbl[7] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 5'd2,  5'd10, 5'd9,  32'd3,         32'h1234_5678, 32'hA5A5_A5A5};
        tbl[8] = '{1'b0, 5'd0,  32'd0,         5'd31, 5'd0,  5'd31, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF};

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].we, tbl[i].a3, tbl[i].wd, tbl[i].a1, tbl[i].a2, tbl[i].ad);
            #2;
            check($sformatf("vec%0d_rd1", i), rf_if.RD1, tbl[i].e1);
            check($sformatf("vec%0d_rd2", i), rf_if.RD2, tbl[i].e2);
            check($sformatf("vec%0d_rdbg", i), rf_if.RDBG, tbl[i].ed);
            edge_step();
        end

        // Operands as the alu would see them for SUB x1 - x2.
        drive(1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 5'd0);
        #2;
        check("alu_sub_operands", rf_if.RD1 - rf_if.RD2, 32'hFFFF_FFF8);

        // Same-cycle read-after-write on x7.
        drive(1'b1, 5'd7, 32'h0000_0010, 5'd0, 5'd0, 5'd0);
        edge_step();
        drive(1'b1, 5'd7, 32'h0000_0020, 5'd7, 5'd0, 5'd7);
        #2;
        check("raw_x7_before", rf_if.RD1, BYP ? 32'h0000_0020 : 32'h0000_0010);
        check("raw_x7_dbg_before", rf_if.RDBG, BYP ? 32'h0000_0020 : 32'h0000_0010);
        edge_step();
        drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd0, 5'd0);
        #2;
        check("raw_x7_after", rf_if.RD1, 32'h0000_0020);

        // Mid-cycle asynchronous reset, then a write held across an edge in reset.
        drive(1'b1, 5'd5, 32'h0000_1234, 5'd0, 5'd0, 5'd0);
        edge_step();
        drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd31, 5'd5);
        #2;
        check("pre_reset_x5", rf_if.RD1, 32'h0000_1234);
        check("pre_reset_x31", rf_if.RD2, 32'hFFFF_FFFF);
        #1;
        rst_n = 1'b0;
        clear_model();
        #1;
        check("async_reset_x5", rf_if.RD1, 32'd0);
        check("async_reset_x31", rf_if.RD2, 32'd0);
        check("async_reset_dbg", rf_if.RDBG, 32'd0);
        drive(1'b1, 5'd4, 32'h0000_0055, 5'd4, 5'd4, 5'd4);
        #1;
        check("in_reset_no_fwd", rf_if.RD1, 32'd0);
        edge_step();
        rf_if.WE3 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_write_x4", rf_if.RD1, 32'd0);
        check("reset_write_x4_dbg", rf_if.RDBG, 32'd0);
        edge_step();

        // Random traffic on a small register window to provoke address collisions.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] a3, a1, a2, ad;
            a3 = 5'($urandom_range(0, 12));
            a1 = 5'($urandom_range(0, 12));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 12));
            ad = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), a3, $urandom, a1, a2, ad);
            #2;
            check("rand_rd1", rf_if.RD1, mread(a1));
            check("rand_rd2", rf_if.RD2, mread(a2));
            check("rand_rdbg", rf_if.RDBG, mread(ad));
            edge_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
